// File: rtl/keypad_pkg.sv
// Shared types and the key legend table for the 4x4 keypad emulator and its scanner.
// The row/column positions follow the physical keypad layout.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE           = 2'd0,
        ST_BOUNCE_PRESS   = 2'd1,
        ST_HELD           = 2'd2,
        ST_BOUNCE_RELEASE = 2'd3
    } emu_state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
    function automatic key_pos_t hex_to_pos(input logic [3:0] hex);
        key_pos_t pos;
        case (hex)
            4'h1: pos = '{row: 2'd0, col: 2'd0};
            4'h2: pos = '{row: 2'd0, col: 2'd1};
            4'h3: pos = '{row: 2'd0, col: 2'd2};
            4'hA: pos = '{row: 2'd0, col: 2'd3};
            4'h4: pos = '{row: 2'd1, col: 2'd0};
            4'h5: pos = '{row: 2'd1, col: 2'd1};
            4'h6: pos = '{row: 2'd1, col: 2'd2};
            4'hB: pos = '{row: 2'd1, col: 2'd3};
            4'h7: pos = '{row: 2'd2, col: 2'd0};
            4'h8: pos = '{row: 2'd2, col: 2'd1};
            4'h9: pos = '{row: 2'd2, col: 2'd2};
            4'hC: pos = '{row: 2'd2, col: 2'd3};
            4'hE: pos = '{row: 2'd3, col: 2'd0};
            4'h0: pos = '{row: 2'd3, col: 2'd1};
            4'hF: pos = '{row: 2'd3, col: 2'd2};
            default: pos = '{row: 2'd3, col: 2'd3};
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// 8-bit Galois LFSR that supplies the pseudo-random contact level while a key bounces.
// It advances only while enabled so the bounce pattern is reproducible from reset.
module bounce_lfsr
    import keypad_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bit_out
);

    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= SEED;
        else if (enable)
            lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
    end

    assign bit_out = lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad: pulls the stored key's column low while its row is driven low.
// Define KEYPAD_BOUNCE_EN to add LFSR-driven contact bounce on press and release.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int         BOUNCE_CYC = 16,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press_req,
    input  logic       release_req,
    input  logic [3:0] key_hex,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       contact,
    output logic       busy,
    output logic       req_err
);

    localparam logic [1:0] S_IDLE           = ST_IDLE;
    localparam logic [1:0] S_BOUNCE_PRESS   = ST_BOUNCE_PRESS;
    localparam logic [1:0] S_HELD           = ST_HELD;
    localparam logic [1:0] S_BOUNCE_RELEASE = ST_BOUNCE_RELEASE;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       contact_nxt;
    key_pos_t   pos;
    logic       press_ok;
    logic       release_ok;

    // Any request that is not a lone, state-appropriate request is rejected.
    assign press_ok   = press_req & ~release_req & (state == S_IDLE);
    assign release_ok = release_req & ~press_req & (state == S_HELD);

`ifdef KEYPAD_BOUNCE_EN
    localparam int             CW        = $clog2(BOUNCE_CYC + 1);
    localparam logic [CW-1:0]  BCNT_LAST = CW'(BOUNCE_CYC - 1);

    logic [CW-1:0] bcnt;
    logic          lfsr_bit;

    assign busy = (state == S_BOUNCE_PRESS) | (state == S_BOUNCE_RELEASE);

    bounce_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (busy),
        .bit_out(lfsr_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bcnt <= '0;
        else if (press_ok | release_ok)
            bcnt <= '0;
        else if (busy)
            bcnt <= bcnt + 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        contact_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_ok)
                    state_nxt = S_BOUNCE_PRESS;
            end
            S_BOUNCE_PRESS: begin
                contact_nxt = lfsr_bit;
                if (bcnt == BCNT_LAST)
                    state_nxt = S_HELD;
            end
            S_HELD: begin
                contact_nxt = 1'b1;
                if (release_ok)
                    state_nxt = S_BOUNCE_RELEASE;
            end
            default: begin
                contact_nxt = lfsr_bit;
                if (bcnt == BCNT_LAST)
                    state_nxt = S_IDLE;
            end
        endcase
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{BOUNCE_CYC, LFSR_SEED};
    assign busy       = 1'b0;

    always_comb begin
        state_nxt   = state;
        contact_nxt = (state == S_HELD);
        if (press_ok)
            state_nxt = S_HELD;
        else if (release_ok)
            state_nxt = S_IDLE;
    end
`endif

    // Contact lags the state by one edge, giving a clean settle after each bounce window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            contact <= 1'b0;
            req_err <= 1'b0;
            pos     <= '0;
        end else begin
            state   <= state_nxt;
            contact <= contact_nxt;
            req_err <= (press_req | release_req) & ~press_ok & ~release_ok;
            if (press_ok)
                pos <= hex_to_pos(key_hex);
        end
    end

    always_comb begin
        cols = 4'b1111;
        if (contact && !rows[pos.row])
            cols[pos.col] = 1'b0;
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator; follows KEYPAD_BOUNCE_EN to pick the expected timing.
// Reference model tracks the logical key level and accept timestamps rather than FSM states.
`timescale 1ns/1ps
module tb_keypad_emulator;

`ifdef KEYPAD_BOUNCE_EN
    localparam int B = 16;
`else
    localparam int B = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       press_req = 1'b0;
    logic       release_req = 1'b0;
    logic [3:0] key_hex = 4'h0;
    logic [3:0] rows = 4'b0000;
    logic [3:0] cols;
    logic       contact;
    logic       busy;
    logic       req_err;

    int errors = 0;
    int checks = 0;

    keypad_emulator #(
        .BOUNCE_CYC(16),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .press_req  (press_req),
        .release_req(release_req),
        .key_hex    (key_hex),
        .rows       (rows),
        .cols       (cols),
        .contact    (contact),
        .busy       (busy),
        .req_err    (req_err)
    );

    always #5 clk = ~clk;

    logic [3:0] legend [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                  '{4'h4, 4'h5, 4'h6, 4'hB},
                                  '{4'h7, 4'h8, 4'h9, 4'hC},
                                  '{4'hE, 4'h0, 4'hF, 4'hD}};

    int         edge_n;
    int         m_acc;
    bit         m_down;
    logic [7:0] m_lfsr;
    logic       m_contact, m_busy, m_err;
    logic [1:0] m_row, m_col;

    function automatic void model_reset();
        m_acc = -1000; m_down = 0; m_lfsr = 8'hA5;
        m_contact = 0; m_busy = 0; m_err = 0; m_row = 0; m_col = 0;
    endfunction

    // A key bounces for B edges after each accepted request, then settles to its target level.
    function automatic void model_edge(input logic p, input logic r, input logic [3:0] h);
        bit was_busy;
        edge_n++;
        was_busy = (edge_n - 1 - m_acc) < B;
        m_contact = was_busy ? m_lfsr[0] : m_down;
        if (was_busy)
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
        m_err = 0;
        if (p && !r && !m_down && !was_busy) begin
            m_down = 1; m_acc = edge_n;
            for (int rr = 0; rr < 4; rr++)
                for (int cc = 0; cc < 4; cc++)
                    if (legend[rr][cc] == h) begin m_row = 2'(rr); m_col = 2'(cc); end
        end else if (r && !p && m_down && !was_busy) begin
            m_down = 0; m_acc = edge_n;
        end else if (p || r) begin
            m_err = 1;
        end
        m_busy = (edge_n - m_acc) < B;
    endfunction

    function automatic logic [3:0] exp_cols(input logic [3:0] rw);
        if (m_contact && (rw[m_row] == 1'b0))
            return ~(4'b0001 << m_col);
        return 4'b1111;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_edge(press_req, release_req, key_hex);
    end

    task automatic step(input logic p, input logic r, input logic [3:0] h, input logic [3:0] rw);
        @(negedge clk);
        press_req = p; release_req = r; key_hex = h; rows = rw;
        @(posedge clk);
        #1;
        press_req = 0; release_req = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
    endtask

    task automatic test_reset();
        reset = 0; rows = 4'b0000;
        #22 reset = 1;
        #1;
        checks++; if (cols !== 4'b1111) begin errors++; $display("[TB] FAIL reset_cols got %b exp 1111", cols); end
        checks++; if (contact !== 1'b0) begin errors++; $display("[TB] FAIL reset_contact got %b exp 0", contact); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (req_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b exp 0", req_err); end
    endtask

    task automatic test_press_key5();
        step(1, 0, 4'h5, 4'b1111);
        for (int i = 0; i < B + 2; i++) begin
            step(0, 0, 4'h5, 4'b1111);
            checks++; if (contact !== m_contact) begin errors++; $display("[TB] FAIL k5_contact got %b exp %b", contact, m_contact); end
            checks++; if (busy !== m_busy) begin errors++; $display("[TB] FAIL k5_busy got %b exp %b", busy, m_busy); end
        end
        rows = 4'b1101; #1;
        checks++; if (cols !== 4'b1101) begin errors++; $display("[TB] FAIL k5_cols_hit got %b exp 1101", cols); end
        rows = 4'b1110; #1;
        checks++; if (cols !== 4'b1111) begin errors++; $display("[TB] FAIL k5_cols_other got %b exp 1111", cols); end
        step(0, 1, 4'h5, 4'b1111);
        for (int i = 0; i < B + 2; i++) step(0, 0, 4'h5, 4'b1111);
        checks++; if (contact !== 1'b0) begin errors++; $display("[TB] FAIL k5_released got %b exp 0", contact); end
    endtask

    task automatic test_bounce_sequence();
        int busy_cycles = 0;
        pulse_reset();
        step(1, 0, 4'hD, 4'b1111);
        if (busy) busy_cycles++;
        for (int i = 1; i <= B + 2; i++) begin
            step(0, 0, 4'hD, 4'b1111);
            if (busy) busy_cycles++;
            checks++; if (contact !== m_contact) begin errors++; $display("[TB] FAIL kd_contact_seq cycle %0d got %b exp %b", i, contact, m_contact); end
            if (i == B + 1) begin
                checks++; if (contact !== 1'b1) begin errors++; $display("[TB] FAIL kd_settled got %b exp 1", contact); end
            end
        end
        checks++; if (busy_cycles != B) begin errors++; $display("[TB] FAIL kd_busy_len got %0d exp %0d", busy_cycles, B); end
        rows = 4'b0111; #1;
        checks++; if (cols !== 4'b0111) begin errors++; $display("[TB] FAIL kd_cols got %b exp 0111", cols); end
        step(0, 1, 4'hD, 4'b1111);
        for (int i = 0; i < B + 2; i++) step(0, 0, 4'hD, 4'b1111);
    endtask

    task automatic test_req_err();
        step(0, 1, 4'h0, 4'b1111);
        checks++; if (req_err !== 1'b1) begin errors++; $display("[TB] FAIL err_release_idle got %b exp 1", req_err); end
        step(0, 0, 4'h0, 4'b1111);
        checks++; if (req_err !== 1'b0) begin errors++; $display("[TB] FAIL err_one_cycle got %b exp 0", req_err); end
        step(1, 1, 4'h3, 4'b1111);
        checks++; if (req_err !== 1'b1 || contact !== 1'b0) begin errors++; $display("[TB] FAIL err_both_idle got err=%b contact=%b exp err=1 contact=0", req_err, contact); end
        step(1, 0, 4'h3, 4'b1111);
        step(0, 0, 4'h3, 4'b1111);
        step(1, 0, 4'h7, 4'b1111);
        checks++; if (req_err !== 1'b1) begin errors++; $display("[TB] FAIL err_press_busy got %b exp 1", req_err); end
        for (int i = 3; i <= B + 1; i++) step(0, 0, 4'h3, 4'b1111);
        checks++; if (contact !== 1'b1) begin errors++; $display("[TB] FAIL err_on_schedule got %b exp 1", contact); end
        rows = 4'b1110; #1;
        checks++; if (cols !== 4'b1011) begin errors++; $display("[TB] FAIL err_pos_kept got %b exp 1011", cols); end
        step(1, 1, 4'h3, 4'b1110);
        checks++; if (req_err !== 1'b1 || contact !== 1'b1) begin errors++; $display("[TB] FAIL err_both_held got err=%b contact=%b exp err=1 contact=1", req_err, contact); end
        step(0, 1, 4'h3, 4'b1111);
        for (int i = 0; i < B + 2; i++) step(0, 0, 4'h3, 4'b1111);
    endtask

    task automatic test_reset_mid();
        step(1, 0, 4'h0, 4'b0111);
        for (int i = 0; i < B + 2; i++) step(0, 0, 4'h0, 4'b0111);
        checks++; if (cols !== 4'b1101) begin errors++; $display("[TB] FAIL mid_cols_held got %b exp 1101", cols); end
`ifdef KEYPAD_BOUNCE_EN
        step(0, 1, 4'h0, 4'b0111);
        for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 4'b0111);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_bounce got %b exp 1", busy); end
`endif
        @(negedge clk); #2 reset = 0; #1;
        checks++; if (cols !== 4'b1111) begin errors++; $display("[TB] FAIL mid_cols_async got %b exp 1111", cols); end
        checks++; if (contact !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_outputs got contact=%b busy=%b exp 0 0", contact, busy); end
        @(negedge clk); #2 reset = 1;
        step(1, 0, 4'h8, 4'b1011);
        checks++; if (req_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_accept got %b exp 0", req_err); end
        for (int i = 0; i < B + 1; i++) step(0, 0, 4'h8, 4'b1011);
        checks++; if (cols !== 4'b1101) begin errors++; $display("[TB] FAIL mid_new_key got %b exp 1101", cols); end
        step(0, 1, 4'h8, 4'b1111);
        for (int i = 0; i < B + 2; i++) step(0, 0, 4'h8, 4'b1111);
    endtask

`ifndef KEYPAD_BOUNCE_EN
    task automatic test_no_bounce();
        step(1, 0, 4'hA, 4'b1110);
        checks++; if (contact !== 1'b0) begin errors++; $display("[TB] FAIL nb_contact_k got %b exp 0", contact); end
        step(0, 0, 4'hA, 4'b1110);
        checks++; if (contact !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL nb_contact_k1 got contact=%b busy=%b exp 1 0", contact, busy); end
        checks++; if (cols !== 4'b0111) begin errors++; $display("[TB] FAIL nb_cols got %b exp 0111", cols); end
        step(0, 1, 4'hA, 4'b1110);
        step(0, 0, 4'hA, 4'b1110);
        checks++; if (contact !== 1'b0 || cols !== 4'b1111) begin errors++; $display("[TB] FAIL nb_release got contact=%b cols=%b exp 0 1111", contact, cols); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 6) == 0, ($urandom % 6) == 0, 4'($urandom), 4'($urandom));
            checks++; if (contact !== m_contact) begin errors++; $display("[TB] FAIL rnd_contact cycle %0d got %b exp %b", i, contact, m_contact); end
            checks++; if (busy !== m_busy) begin errors++; $display("[TB] FAIL rnd_busy cycle %0d got %b exp %b", i, busy, m_busy); end
            checks++; if (req_err !== m_err) begin errors++; $display("[TB] FAIL rnd_err cycle %0d got %b exp %b", i, req_err, m_err); end
            checks++; if (cols !== exp_cols(rows)) begin errors++; $display("[TB] FAIL rnd_cols cycle %0d got %b exp %b", i, cols, exp_cols(rows)); end
        end
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        test_reset();
        test_press_key5();
        test_bounce_sequence();
        test_req_err();
        test_reset_mid();
`ifndef KEYPAD_BOUNCE_EN
        test_no_bounce();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
